// File: rtl/data_mem_bridge.sv
// -----------------------------------------------------------------------------
// data_mem_bridge
//
// Adapts the single-cycle data port of the ArmCpu core to a valid/ready memory
// bus with variable read latency. Stores are posted into a small circular
// write buffer and drained in order in the background. Loads stall the CPU,
// wait until every buffered store has reached the bus, and only then issue
// the read, so a load always sees the data of earlier stores.
//
// Ports
//   clk, reset_n        rising-edge clock, asynchronous active-low reset
//   cpu_req/cpu_we      CPU access valid / 1 = store, 0 = load
//   cpu_addr/cpu_wdata  CPU byte address / store data
//   cpu_rdata           load data, non-zero only in the load-completion cycle
//   cpu_stall           CPU must hold its request stable
//   mem_valid/mem_ready bus request handshake
//   mem_we/mem_addr/mem_wdata   bus request payload (word-aligned address)
//   mem_rvalid/mem_rdata        read response, at least one cycle after accept
//   wb_count            number of stores currently buffered
//   align_err           sticky flag, set by any misaligned access
// -----------------------------------------------------------------------------
module data_mem_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int WB_DEPTH   = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cpu_req,
  input  logic                      cpu_we,
  input  logic [ADDR_WIDTH-1:0]     cpu_addr,
  input  logic [DATA_WIDTH-1:0]     cpu_wdata,
  output logic [DATA_WIDTH-1:0]     cpu_rdata,
  output logic                      cpu_stall,
  output logic                      mem_valid,
  input  logic                      mem_ready,
  output logic                      mem_we,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic                      mem_rvalid,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic [$clog2(WB_DEPTH):0] wb_count,
  output logic                      align_err
);

  localparam int CNT_W = $clog2(WB_DEPTH) + 1;
  localparam int PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WB_DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(WB_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_RD_REQ,
    S_RD_WAIT,
    S_RD_DONE
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] wb_addr_q [WB_DEPTH];
  logic [DATA_WIDTH-1:0] wb_data_q [WB_DEPTH];

  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  align_err_q, align_err_d;

  logic aligned;
  logic wb_empty;
  logic wb_full;
  logic drain_active;
  logic load_req;
  logic accept;
  logic push;
  logic pop;

  assign aligned  = (cpu_addr[1:0] == 2'b00);
  assign wb_empty = (count_q == '0);
  assign wb_full  = (count_q == FULL_CNT);
  assign load_req = cpu_req && !cpu_we && aligned;

  // The buffer drains only while no load owns the bus.
  assign drain_active = ((state_q == S_IDLE) || (state_q == S_DRAIN)) && !wb_empty;

  // Stall is derived from registered state only: a store into a full buffer
  // waits even if the head pops on the same edge.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    cpu_stall = 1'b0;
    if (cpu_req && aligned) begin
      if (cpu_we) begin
        cpu_stall = wb_full;
      end else begin
        cpu_stall = (state_q != S_RD_DONE);
      end
    end
  end

  assign accept = cpu_req && !cpu_stall;
  assign push   = accept && cpu_we && aligned;
  assign pop    = drain_active && mem_ready;

  // Bus request mux: buffered writes first, then the pending load.
  always_comb begin
    mem_valid = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (drain_active) begin
      mem_valid = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = wb_addr_q[head_q];
      mem_wdata = wb_data_q[head_q];
    end else if (state_q == S_RD_REQ) begin
      mem_valid = 1'b1;
      mem_addr  = {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
    end
  end

  assign cpu_rdata = (state_q == S_RD_DONE) ? rdata_q : '0;
  assign wb_count  = count_q;
  assign align_err = align_err_q;

  // Buffer pointer and occupancy update.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      head_d = (head_q == LAST_PTR) ? '0 : head_q + 1'b1;
    end
    if (push) begin
      tail_d = (tail_q == LAST_PTR) ? '0 : tail_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + ONE_CNT;
      2'b01:   count_d = count_q - ONE_CNT;
      default: count_d = count_q;
    endcase
  end

  // Load sequencing FSM.
  always_comb begin
    state_d     = state_q;
    rdata_d     = rdata_q;
    align_err_d = align_err_q || (cpu_req && !aligned);
    case (state_q)
      S_IDLE: begin
        if (load_req) begin
          state_d = wb_empty ? S_RD_REQ : S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Leave as soon as the buffer is empty, counting a pop of the last
        // entry on this edge.
        if (wb_empty || ((count_q == ONE_CNT) && pop)) begin
          state_d = S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        if (mem_ready) begin
          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (mem_rvalid) begin
          rdata_d = mem_rdata;
          state_d = S_RD_DONE;
        end
      end
      S_RD_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      rdata_q     <= '0;
      align_err_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      rdata_q     <= rdata_d;
      align_err_q <= align_err_d;
    end
  end

  // NOTE: the buffer storage is not reset; occupancy lives in count_q, so an
  // entry is never read before it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      wb_addr_q[tail_q] <= cpu_addr;
      wb_data_q[tail_q] <= cpu_wdata;
    end
  end

endmodule

// File: tb/tb_data_mem_bridge.sv
// -----------------------------------------------------------------------------
// tb_data_mem_bridge
//
// Directed and randomized bench for data_mem_bridge (WB_DEPTH = 2). A bus
// responder with its own memory serves the bridge; a separate reference
// memory, updated when the CPU's stores are accepted, predicts load data.
// Expected store order is kept in a queue and compared with the writes seen
// on the bus.
// -----------------------------------------------------------------------------
module tb_data_mem_bridge;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic                   cpu_req;
  logic                   cpu_we;
  logic [AW-1:0]          cpu_addr;
  logic [DW-1:0]          cpu_wdata;
  logic [DW-1:0]          cpu_rdata;
  logic                   cpu_stall;
  logic                   mem_valid;
  logic                   mem_ready;
  logic                   mem_we;
  logic [AW-1:0]          mem_addr;
  logic [DW-1:0]          mem_wdata;
  logic                   mem_rvalid;
  logic [DW-1:0]          mem_rdata;
  logic [$clog2(DEPTH):0] wb_count;
  logic                   align_err;

  always #5 clk = ~clk;

  data_mem_bridge #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .WB_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
    .wb_count  (wb_count),
    .align_err (align_err)
  );

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } bus_op_t;

  bus_op_t       bus_log[$];
  bus_op_t       exp_wr[$];
  bus_op_t       wr_seen[$];
  logic [DW-1:0] bus_mem [logic [AW-1:0]];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];

  bit            ready_hi   = 1'b0;
  bit            ready_rand = 1'b0;
  int            rd_lat     = 1;
  int            rd_cnt     = 0;
  logic [DW-1:0] rd_pend;
  bit            rst_seen   = 1'b0;

  int n_checks = 0;
  int n_fails  = 0;

  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return a ^ 32'h5a5a_0000;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bus responder: handshakes sampled mid-cycle, responses driven 1 time unit
  // after the rising edge.
  initial begin
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      bus_op_t op;
      bit      hs;
      @(negedge clk);
      hs      = reset_n && mem_valid && mem_ready;
      op.we   = mem_we;
      op.addr = mem_addr;
      op.data = mem_wdata;
      @(posedge clk);
      #1;
      if (hs && reset_n) begin
        bus_log.push_back(op);
        if (op.we) begin
          bus_mem[op.addr] = op.data;
        end else begin
          rd_cnt  = rd_lat;
          rd_pend = bus_mem.exists(op.addr) ? bus_mem[op.addr] : dflt(op.addr);
        end
      end
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rd_pend;
        end
      end
      mem_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_hi;
    end
  end

  // A request left waiting must keep its payload until accepted.
  always @(negedge reset_n) rst_seen = 1'b1;

  initial begin
    bit      pend;
    bus_op_t prev;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pend && !rst_seen) begin
        check("valid_stable", mem_valid, 1);
        check("we_stable", mem_we, prev.we);
        check("addr_stable", mem_addr, prev.addr);
        if (prev.we) check("wdata_stable", mem_wdata, prev.data);
      end
      if (reset_n) check("wb_count_bound", wb_count <= DEPTH, 1);
      rst_seen  = 1'b0;
      pend      = reset_n && mem_valid && !mem_ready;
      prev.we   = mem_we;
      prev.addr = mem_addr;
      prev.data = mem_wdata;
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One CPU access: holds the request until the stall clears, then lets the
  // accepting edge pass. Reports stall cycles and the data seen on acceptance.
  task automatic access(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int stalls, output logic [DW-1:0] rd);
    bus_op_t e;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = d;
    stalls    = 0;
    #1;
    while (cpu_stall === 1'b1 && stalls < 300) begin
      tick();
      stalls++;
    end
    if (stalls >= 300) check("access_timeout", cpu_stall, 0);
    rd = cpu_rdata;
    if (we && a[1:0] == 2'b00) begin
      e.we   = 1'b1;
      e.addr = a;
      e.data = d;
      exp_wr.push_back(e);
      ref_mem[a] = d;
    end
    tick();
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
  endtask

  task automatic wait_drained(input string tag);
    int n;
    n = 0;
    while ((wb_count !== '0 || mem_valid !== 1'b0 || rd_cnt != 0) && n < 300) begin
      tick();
      n++;
    end
    check(tag, wb_count, 0);
  endtask

  initial begin
    int            st;
    int            n;
    logic [DW-1:0] rd;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] exp_v;
    bit            we;

    reset_n   = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    #3;
    check("rst_mem_valid", mem_valid, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_cpu_stall", cpu_stall, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_align_err", align_err, 0);
    check("rst_wb_count", wb_count, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Posted store with the bus blocked, then released.
    ready_hi = 1'b0;
    tick();
    access(1'b1, 32'h100, 32'd7, st, rd);
    check("post_stall", st, 0);
    check("post_count", wb_count, 1);
    check("post_valid", mem_valid, 1);
    check("post_we", mem_we, 1);
    check("post_addr", mem_addr, 32'h100);
    check("post_wdata", mem_wdata, 32'd7);
    tick();
    tick();
    check("post_held_count", wb_count, 1);
    n = bus_log.size();
    ready_hi = 1'b1;
    wait_drained("post_drained");
    check("post_bus_writes", bus_log.size() - n, 1);
    if (bus_log.size() > n) begin
      check("post_bus_addr", bus_log[n].addr, 32'h100);
      check("post_bus_data", bus_log[n].data, 32'd7);
    end

    // Buffer full: third store waits for exactly one pop.
    ready_hi = 1'b0;
    tick();
    tick();
    n = bus_log.size();
    access(1'b1, 32'h200, 32'hA1, st, rd);
    check("full_st1_stall", st, 0);
    access(1'b1, 32'h204, 32'hA2, st, rd);
    check("full_st2_stall", st, 0);
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 32'h208;
    cpu_wdata = 32'hA3;
    #1;
    check("full_stall", cpu_stall, 1);
    check("full_count", wb_count, 2);
    ready_hi = 1'b1;
    tick();
    ready_hi = 1'b0;
    check("full_stall_ready_cycle", cpu_stall, 1);
    tick();
    check("full_stall_released", cpu_stall, 0);
    check("full_count_after_pop", wb_count, 1);
    begin
      bus_op_t e;
      e.we = 1'b1; e.addr = 32'h208; e.data = 32'hA3;
      exp_wr.push_back(e);
      ref_mem[32'h208] = 32'hA3;
    end
    tick();
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    check("full_count_after_push", wb_count, 2);
    ready_hi = 1'b1;
    wait_drained("full_drained");
    check("full_bus_writes", bus_log.size() - n, 3);
    if (bus_log.size() >= n + 3) begin
      check("full_order0", bus_log[n].addr, 32'h200);
      check("full_order1", bus_log[n+1].addr, 32'h204);
      check("full_order2", bus_log[n+2].addr, 32'h208);
      check("full_order2_data", bus_log[n+2].data, 32'hA3);
    end

    // Store then load to the same address: read must follow the write.
    ready_hi = 1'b1;
    tick();
    access(1'b1, 32'h44, 32'hdeadbeef, st, rd);
    check("raw_store_stall", st, 0);
    access(1'b0, 32'h44, 32'h0, st, rd);
    check("raw_load_stall", st, 4);
    check("raw_load_data", rd, 32'hdeadbeef);
    n = bus_log.size();
    if (n >= 2) begin
      check("raw_first_is_write", bus_log[n-2].we, 1);
      check("raw_write_addr", bus_log[n-2].addr, 32'h44);
      check("raw_then_read", bus_log[n-1].we, 0);
      check("raw_read_addr", bus_log[n-1].addr, 32'h44);
    end

    // Load latency with a slow read response.
    bus_mem[32'h300] = 32'hff;
    ref_mem[32'h300] = 32'hff;
    rd_lat = 3;
    access(1'b0, 32'h300, 32'h0, st, rd);
    check("lat_stall", st, 5);
    check("lat_data", rd, 32'hff);
    check("lat_rdata_cleared", cpu_rdata, 0);
    rd_lat = 1;

    // Misaligned accesses.
    n = bus_log.size();
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h102;
    #1;
    check("mis_ld_stall", cpu_stall, 0);
    check("mis_ld_valid", mem_valid, 0);
    check("mis_ld_rdata", cpu_rdata, 0);
    tick();
    cpu_req = 1'b0;
    check("mis_align_err", align_err, 1);
    access(1'b1, 32'h101, 32'h55, st, rd);
    check("mis_st_stall", st, 0);
    check("mis_st_count", wb_count, 0);
    check("mis_st_valid", mem_valid, 0);
    check("mis_no_bus", bus_log.size() - n, 0);
    access(1'b1, 32'h10, 32'h1234, st, rd);
    access(1'b0, 32'h10, 32'h0, st, rd);
    check("mis_then_load_data", rd, 32'h1234);
    check("mis_err_sticky", align_err, 1);

    // Randomized traffic with a randomly stalling bus.
    ready_rand = 1'b1;
    for (int i = 0; i < 60; i++) begin
      we = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 15)) << 2;
      d  = $urandom;
      rd_lat = $urandom_range(1, 4);
      if (we) begin
        access(1'b1, a, d, st, rd);
      end else begin
        exp_v = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
        access(1'b0, a, 32'h0, st, rd);
        check("rand_load_data", rd, exp_v);
        check("rand_load_min_stall", st >= 3, 1);
      end
    end
    ready_rand = 1'b0;
    ready_hi   = 1'b1;
    rd_lat     = 1;
    wait_drained("rand_drained");

    foreach (bus_log[i]) begin
      if (bus_log[i].we) wr_seen.push_back(bus_log[i]);
    end
    check("wr_total", wr_seen.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < wr_seen.size(); i++) begin
      check("wr_order_addr", wr_seen[i].addr, exp_wr[i].addr);
      check("wr_order_data", wr_seen[i].data, exp_wr[i].data);
    end

    // Reset while a buffered write is on the bus.
    ready_hi = 1'b0;
    tick();
    tick();
    access(1'b1, 32'h400, 32'h77, st, rd);
    check("rstw_count_before", wb_count, 1);
    check("rstw_valid_before", mem_valid, 1);
    reset_n = 1'b0;
    #1;
    check("rstw_valid", mem_valid, 0);
    check("rstw_we", mem_we, 0);
    check("rstw_count", wb_count, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("rstw_count_after", wb_count, 0);
    check("rstw_err_cleared", align_err, 0);

    // Reset while a load waits for its response; the late response is ignored.
    ready_hi = 1'b1;
    rd_lat   = 4;
    tick();
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h80;
    tick();
    tick();
    check("rstl_stall_in_wait", cpu_stall, 1);
    reset_n = 1'b0;
    cpu_req = 1'b0;
    #1;
    check("rstl_valid", mem_valid, 0);
    check("rstl_stall", cpu_stall, 0);
    check("rstl_count", wb_count, 0);
    check("rstl_rdata", cpu_rdata, 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rstl_rdata_late", cpu_rdata, 0);
      check("rstl_no_stall", cpu_stall, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/data_mem_bridge.md
# data_mem_bridge

Data-side memory bridge sitting directly downstream of the single-cycle `ArmCpu` data port (`mem_write`, `data_memory_addr`, `write_data`, `read_data`). It converts the CPU's zero-latency memory assumption into a valid/ready bus with variable latency. It absorbs stores in a small posted-write buffer and stalls the CPU only for loads or when the buffer is full. Loads are ordered behind all buffered stores, so read-after-write is always coherent.

## Interface
- `ADDR_WIDTH`, default 32: byte address width.
- `DATA_WIDTH`, default 32: word width.
- `WB_DEPTH`, default 2: write-buffer entries. Power of two, 1..8.

- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `cpu_req`  in  1  CPU data access valid this cycle.
- `cpu_we`  in  1  1 = store, 0 = load. Connected to `mem_write`.
- `cpu_addr`  in  ADDR_WIDTH  connected to `data_memory_addr`.
- `cpu_wdata`  in  DATA_WIDTH  connected to `write_data`.
- `cpu_rdata`  out  DATA_WIDTH  load data, feeds `read_data`.
- `cpu_stall`  out  1  CPU must hold PC and the request stable.
- `mem_valid`  out  1  bus request valid.
- `mem_ready`  in  1  bus accepts request.
- `mem_we`  out  1  bus write.
- `mem_addr`  out  ADDR_WIDTH  bus word address (byte address, [1:0]=0).
- `mem_wdata`  out  DATA_WIDTH  bus write data.
- `mem_rvalid`  in  1  read data valid. Arrives ≥1 cycle after the read handshake.
- `mem_rdata`  in  DATA_WIDTH  read data.
- `wb_count`  out  $clog2(WB_DEPTH)+1  buffered stores.
- `align_err`  out  1  sticky misaligned-access flag.

## Operation
- A CPU access is accepted on a rising edge where `cpu_req=1` and `cpu_stall=0`. While stalled, the CPU holds all `cpu_*` inputs stable.
- **Store**
  - `cpu_stall = (wb_count==WB_DEPTH)`, computed from the registered count only. There is no same-cycle push/pop bypass.
  - On acceptance, {addr, wdata} is pushed at the tail and the tail pointer wraps modulo WB_DEPTH.
- **Load**
  - `cpu_stall=1` in every state except RD_DONE.
- **Misaligned access** (`cpu_addr[1:0]!=0`)
  - Accepted with `cpu_stall=0`.
  - No buffer push and no bus access.
  - `cpu_rdata=0`.
  - `align_err` is set and stays set until reset.
- **Drain**
  - In IDLE and DRAIN with the buffer non-empty, the bridge drives `mem_valid=1`, `mem_we=1`, and the head entry.
  - The head is popped on `mem_valid & mem_ready`.
  - A push and a pop on the same edge leave the count unchanged.
- **FSM**
  - IDLE: on an aligned load request with count==0, go to RD_REQ. With count>0, go to DRAIN.
  - DRAIN: keep draining. When the count reaches 0 (including by a pop on this edge), go to RD_REQ.
  - RD_REQ: drive `mem_valid=1`, `mem_we=0`, `mem_addr=cpu_addr`. Hold until `mem_ready`, then go to RD_WAIT.
  - RD_WAIT: on `mem_rvalid`, capture `mem_rdata` into the rdata register and go to RD_DONE.
  - RD_DONE: `cpu_stall=0` and `cpu_rdata` = the captured register. The load is accepted on this edge; go to IDLE.
- No store can arrive while a load is pending, because the CPU is stalled. The buffer is therefore frozen except for draining.
- `cpu_rdata` is 0 outside RD_DONE.
- `mem_addr` and `mem_wdata` are don't-care when `mem_valid=0`. The bench checks them only when `mem_valid=1`.

## Timing
- **Reset** (asynchronous, immediate):
  - State goes to IDLE and the buffer empties (`wb_count=0`, both pointers 0).
  - `mem_valid=0`, `mem_we=0`, `cpu_stall=0` with no request, `cpu_rdata=0`, `align_err=0`.
  - A bus transaction in flight is abandoned. A late `mem_rvalid` after reset is ignored because the FSM is in IDLE.
- **Store latency:** 0 stall cycles when the buffer is not full. The earliest bus write is the cycle after acceptance.
- **Minimum load, empty buffer, `mem_ready` immediate, `mem_rvalid` one cycle after the handshake:**
  - Cycle 0: request, stall.
  - Cycle 1: RD_REQ with handshake.
  - Cycle 2: RD_WAIT with rvalid.
  - Cycle 3: RD_DONE, stall=0.
  - Result: 3 stall cycles, and the CPU commits the load on the edge closing cycle 3.
- **Load behind N buffered stores with `mem_ready` always high:** 3+N stall cycles.
- **`mem_valid` stability:** once asserted, `mem_valid` and its payload stay stable until `mem_ready`, except on reset.

## Test plan
- **Posted store:** with `mem_ready` held low, STR addr 0x100, data 7, is accepted with no stall and `wb_count=1`. Raise `mem_ready` → one bus write {0x100, 7}, then `wb_count=0`.
- **Buffer full:** `mem_ready=0`, WB_DEPTH=2. Two stores are accepted; a third sees `cpu_stall=1` and `wb_count=2`. Release `mem_ready` for one cycle → the third store is accepted the following cycle. Stores reach the bus in order.
- **Store then load to the same address:** STR 0x44 = 0xdeadbeef, then LDR 0x44. The memory model returns the stored value. The read is issued only after the write handshake, and `cpu_rdata=0xdeadbeef` in RD_DONE with 4 stall cycles.
- **Load latency:** empty buffer, `mem_rvalid` 3 cycles after the handshake, data 0xff → stall for exactly 5 cycles, then `cpu_rdata=0xff`.
- **Misaligned:** LDR at 0x102 → no stall, no `mem_valid`, `cpu_rdata=0`, `align_err=1`. The flag stays 1 after subsequent aligned accesses.
- **Reset mid-load:** assert `reset_n=0` in RD_WAIT → `mem_valid`, `cpu_stall` and `wb_count` drop to 0 asynchronously. A later `mem_rvalid` pulse does not change `cpu_rdata` (stays 0).
